// File: rtl/mseq_pkg.sv
// Shared definitions for the microsequencer instruction-fetch slice:
// fetch FSM encoding and default instruction-word field geometry.
package mseq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // Instruction word is {opcode, operand}; opcode occupies the top bits.
    localparam int MSEQ_OPCODE_WIDTH   = 2;
    localparam int MSEQ_OPERAND_WIDTH  = 6;
    localparam int MSEQ_ADDR_WIDTH     = 5;
    localparam int MSEQ_PREFETCH_DEPTH = 2;
    localparam int MSEQ_RESET_VECTOR   = 16;

endpackage

// File: rtl/mseq_prefetch_fifo.sv
// Small synchronous prefetch FIFO with push, pop, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module mseq_prefetch_fifo #(
    parameter int  WIDTH     = 8,
    parameter int  DEPTH     = 2,
    localparam int PTR_WIDTH = $clog2(DEPTH),
    localparam int CNT_WIDTH = PTR_WIDTH + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 full,
    output logic                 empty
);

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_r;
    logic [PTR_WIDTH-1:0] rd_ptr_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] count_next_s;
    logic                 push_ok_s;
    logic                 pop_ok_s;

    assign full  = (count_r == CNT_WIDTH'(DEPTH));
    assign empty = (count_r == {CNT_WIDTH{1'b0}});
    assign count = count_r;
    assign dout  = mem_r[rd_ptr_r];

    // Qualify requests and compute next occupancy; push+pop leaves count unchanged.
    always_comb begin
        push_ok_s    = push && (!full || pop);
        pop_ok_s     = pop && !empty;
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CNT_WIDTH'(1'b1);
            2'b01:   count_next_s = count_r - CNT_WIDTH'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer and count registers; flush empties the queue.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr_r <= {PTR_WIDTH{1'b0}};
            rd_ptr_r <= {PTR_WIDTH{1'b0}};
            count_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1'b1);
            end
            count_r <= count_next_s;
        end
    end

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/mseq_instr_fetch.sv
// Opcode-side instruction fetch: req/ack memory reads into a prefetch FIFO,
// current instruction held stable. Optional perf counters under IFETCH_PERF_CNT_EN.
module mseq_instr_fetch
    import mseq_pkg::*;
#(
    parameter int OPCODE_WIDTH   = MSEQ_OPCODE_WIDTH,
    parameter int OPERAND_WIDTH  = MSEQ_OPERAND_WIDTH,
    parameter int ADDR_WIDTH     = MSEQ_ADDR_WIDTH,
    parameter int PREFETCH_DEPTH = MSEQ_PREFETCH_DEPTH,
    parameter int RESET_VECTOR   = MSEQ_RESET_VECTOR
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                next,
    input  logic                                load_pc,
    input  logic [ADDR_WIDTH-1:0]               pc_in,
    output logic [OPCODE_WIDTH-1:0]             opcode,
    output logic [OPERAND_WIDTH-1:0]            operand,
    output logic                                stall,
    output logic                                mem_req,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    input  logic                                mem_ack,
    input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] mem_data
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [15:0]                         fetch_count,
    output logic [15:0]                         stall_count
`endif
);

    localparam int WORD_WIDTH = OPCODE_WIDTH + OPERAND_WIDTH;
    localparam int CNT_WIDTH  = $clog2(PREFETCH_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_VECTOR);

    fetch_state_e          state_r;
    fetch_state_e          state_next_s;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] pc_next_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic                  mem_req_r;
    logic                  next_q_r;
    logic                  next_edge_s;
    logic                  accept_s;
    logic                  bypass_s;
    logic                  push_s;
    logic                  pop_s;
    logic [WORD_WIDTH-1:0] cur_word_r;
    logic                  stall_r;
    logic [WORD_WIDTH-1:0] fifo_dout_s;
    logic [CNT_WIDTH-1:0]  fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    mseq_prefetch_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (PREFETCH_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (load_pc),
        .din   (mem_data),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Word routing: a word skips the FIFO only when it would otherwise be the head.
    always_comb begin
        next_edge_s = next & ~next_q_r;
        accept_s    = (state_r == REQ) && mem_ack && !load_pc;
        bypass_s    = accept_s && fifo_empty_s && (stall_r || next_edge_s);
        push_s      = accept_s && !bypass_s && !fifo_full_s;
        pop_s       = next_edge_s && !fifo_empty_s && !load_pc;
        if (load_pc) begin
            pc_next_s = pc_in;
        end else if (accept_s) begin
            pc_next_s = pc_r + ADDR_WIDTH'(1'b1);
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Fetch FSM next state; a redirect during a read must still absorb its ack.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!load_pc && (fifo_count_s < CNT_WIDTH'(PREFETCH_DEPTH))) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_next_s = IDLE;
                end else if (load_pc) begin
                    state_next_s = DROP;
                end else begin
                    state_next_s = REQ;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DROP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM, PC and memory-interface registers; mem_addr is frozen while a read is open.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            mem_req_r  <= 1'b0;
            mem_addr_r <= RESET_PC;
            next_q_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pc_r      <= pc_next_s;
            mem_req_r <= (state_next_s != IDLE);
            next_q_r  <= next;
            if ((state_r == IDLE) || (state_next_s == IDLE)) begin
                mem_addr_r <= pc_next_s;
            end
        end
    end

    // Current instruction register; redirect beats bypass, pop and advance.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cur_word_r <= {WORD_WIDTH{1'b0}};
            stall_r    <= 1'b1;
        end else if (load_pc) begin
            stall_r <= 1'b1;
        end else if (bypass_s) begin
            cur_word_r <= mem_data;
            stall_r    <= 1'b0;
        end else if (pop_s) begin
            cur_word_r <= fifo_dout_s;
            stall_r    <= 1'b0;
        end else if (next_edge_s) begin
            stall_r <= 1'b1;
        end
    end

    assign opcode   = cur_word_r[WORD_WIDTH-1 -: OPCODE_WIDTH];
    assign operand  = cur_word_r[OPERAND_WIDTH-1:0];
    assign stall    = stall_r;
    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetch_count_r;
    logic [15:0] stall_count_r;

    // Saturating accepted-word and stalled-cycle counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_count_r <= 16'h0000;
            stall_count_r <= 16'h0000;
        end else begin
            if (accept_s && (fetch_count_r != 16'hFFFF)) begin
                fetch_count_r <= fetch_count_r + 16'h0001;
            end
            if (stall_r && (stall_count_r != 16'hFFFF)) begin
                stall_count_r <= stall_count_r + 16'h0001;
            end
        end
    end

    assign fetch_count = fetch_count_r;
    assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_mseq_instr_fetch.sv
// Self-checking bench for mseq_instr_fetch: directed scenarios followed by a
// randomized advance/jump phase checked against an address-stream model.
module tb_mseq_instr_fetch;

    logic       clock = 1'b0;
    logic       reset;
    logic       next;
    logic       load_pc;
    logic [4:0] pc_in;
    logic [1:0] opcode;
    logic [5:0] operand;
    logic       stall;
    logic       mem_req;
    logic [4:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_data;
`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    logic       ack_auto  = 1'b0;
    logic       ack_inj   = 1'b0;
    logic [7:0] data_auto = 8'h00;
    logic [7:0] data_inj  = 8'h00;
    int         lat       = 1;
    bit         mem_en    = 1'b0;
    int         mem_cnt   = 0;

    logic [4:0] req_log [$];
    logic       prev_req    = 1'b0;
    logic [4:0] prev_addr   = 5'd0;
    int         stable_viol = 0;

    int         n_cmp = 0;
    int         n_err = 0;
    int         base;
    int         r;
    logic [4:0] exp_addr;
    logic [4:0] tgt;
    logic [7:0] w;

    assign mem_ack  = ack_auto | ack_inj;
    assign mem_data = ack_inj ? data_inj : data_auto;

    mseq_instr_fetch dut (
        .clock    (clock),
        .reset    (reset),
        .next     (next),
        .load_pc  (load_pc),
        .pc_in    (pc_in),
        .opcode   (opcode),
        .operand  (operand),
        .stall    (stall),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clock = ~clock;

    // Program memory contents: opcode = addr[1:0], operand = address.
    function automatic logic [7:0] word_of(input logic [4:0] a);
        return {a[1:0], 1'b0, a};
    endfunction

    // Memory responder: one-cycle ack after lat cycles of an open request.
    always @(negedge clock) begin
        if (!mem_en) begin
            ack_auto <= 1'b0;
            mem_cnt  <= 0;
        end else if (ack_auto) begin
            ack_auto <= 1'b0;
            mem_cnt  <= 0;
        end else if (mem_req) begin
            if (mem_cnt + 1 >= lat) begin
                ack_auto  <= 1'b1;
                data_auto <= word_of(mem_addr);
                mem_cnt   <= 0;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    // Request monitor: log each request start and note address changes mid-request.
    always @(negedge clock) begin
        prev_req  <= mem_req;
        prev_addr <= mem_addr;
        if (mem_req && !prev_req) req_log.push_back(mem_addr);
        if (mem_req && prev_req && (mem_addr != prev_addr)) stable_viol <= stable_viol + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_unstall(input string tag);
        int k = 0;
        while ((stall !== 1'b0) && (k < 60)) begin
            @(negedge clock);
            k++;
        end
        chk(tag, 32'(k < 60), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while ((mem_req !== 1'b1) && (k < 20)) begin
            @(negedge clock);
            k++;
        end
        chk(tag, 32'(k < 20), 32'd1);
    endtask

    task automatic pulse_next();
        next = 1'b1;
        cyc(1);
        next = 1'b0;
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < req_log.size()) return 32'(req_log[i]);
        else return 32'hDEAD_BEEF;
    endfunction

    initial begin
        reset = 1'b0; next = 1'b0; load_pc = 1'b0; pc_in = 5'd0;
        mem_en = 1'b1; lat = 1;
        cyc(3);
        chk("rst_stall",   32'(stall),    32'd1);
        chk("rst_req",     32'(mem_req),  32'd0);
        chk("rst_addr",    32'(mem_addr), 32'd16);
        chk("rst_opcode",  32'(opcode),   32'd0);
        chk("rst_operand", 32'(operand),  32'd0);

        // Startup: first request, bypass, then FIFO fill with 17 and 18.
        reset = 1'b1;
        cyc(1);
        chk("first_req",  32'(mem_req),  32'd1);
        chk("first_addr", 32'(mem_addr), 32'd16);
        cyc(1);
        chk("first_stall",   32'(stall),   32'd0);
        chk("first_operand", 32'(operand), 32'd16);
        chk("first_opcode",  32'(opcode),  32'd0);
        cyc(12);
        chk("fill_pause_req",  32'(mem_req),  32'd0);
        chk("fill_pause_addr", 32'(mem_addr), 32'd19);
        chk("fill_log_n",      32'(req_log.size()), 32'd3);
        chk("fill_log0", log_at(0), 32'd16);
        chk("fill_log1", log_at(1), 32'd17);
        chk("fill_log2", log_at(2), 32'd18);
        chk("hold_operand", 32'(operand), 32'd16);

        // Held next advances exactly once; refetch of 19 follows.
        base = req_log.size();
        next = 1'b1;
        cyc(3);
        chk("adv_once_operand", 32'(operand), 32'd17);
        chk("adv_once_stall",   32'(stall),   32'd0);
        next = 1'b0;
        cyc(6);
        chk("refetch_addr", log_at(base), 32'd19);
        chk("refetch_n",    32'(req_log.size() - base), 32'd1);

        // Drain with 3-cycle memory latency.
        lat = 3;
        cyc(2);
        pulse_next();
        chk("drain1", 32'(operand), 32'd18);
        cyc(1);
        pulse_next();
        chk("drain2", 32'(operand), 32'd19);
        cyc(1);
        pulse_next();
        chk("drain3",       32'(operand), 32'd20);
        chk("drain3_stall", 32'(stall),   32'd0);
        cyc(1);
        pulse_next();
        chk("drain4_stall", 32'(stall), 32'd1);
        wait_unstall("drain5_unstall");
        chk("drain5_operand", 32'(operand), 32'd21);
        chk("drain5_opcode",  32'(opcode),  32'd1);

        // Redirect to 5 while a request is outstanding.
        cyc(12);
        lat = 6;
        pulse_next();
        wait_req("redir_req_seen");
        cyc(1);
        base = req_log.size();
        load_pc = 1'b1; pc_in = 5'd5;
        cyc(1);
        load_pc = 1'b0;
        chk("redir_stall",    32'(stall),   32'd1);
        chk("redir_req_held", 32'(mem_req), 32'd1);
        wait_unstall("redir_unstall");
        chk("redir_operand",  32'(operand), 32'd5);
        chk("redir_next_req", log_at(base), 32'd5);
        pulse_next();
        wait_unstall("redir_adv_unstall");
        chk("redir_flushed", 32'(operand), 32'd6);

        // PC wrap from 31 to 0.
        lat = 1;
        cyc(10);
        base = req_log.size();
        load_pc = 1'b1; pc_in = 5'd31;
        cyc(1);
        load_pc = 1'b0;
        wait_unstall("wrap_unstall");
        chk("wrap_operand", 32'(operand), 32'd31);
        chk("wrap_opcode",  32'(opcode),  32'd3);
        cyc(6);
        chk("wrap_log0", log_at(base),     32'd31);
        chk("wrap_log1", log_at(base + 1), 32'd0);
        pulse_next();
        chk("wrap_adv_operand", 32'(operand), 32'd0);
        chk("wrap_adv_stall",   32'(stall),   32'd0);

        // Reset during an open request, with a late ack arriving under reset.
        lat = 20;
        pulse_next();
        wait_req("midrst_req_seen");
        cyc(1);
        reset = 1'b0;
        cyc(1);
        chk("midrst_req", 32'(mem_req), 32'd0);
        mem_en = 1'b0;
        ack_inj = 1'b1; data_inj = 8'hAA;
        cyc(1);
        ack_inj = 1'b0;
        cyc(1);
        chk("midrst_stall",   32'(stall),    32'd1);
        chk("midrst_operand", 32'(operand),  32'd0);
        chk("midrst_addr",    32'(mem_addr), 32'd16);
        base = req_log.size();
        mem_en = 1'b1; lat = 1;
        reset = 1'b1;
        cyc(1);
        chk("midrst_first_req",  32'(mem_req),  32'd1);
        chk("midrst_first_addr", 32'(mem_addr), 32'd16);
        cyc(1);
        chk("midrst_cur_stall",   32'(stall),   32'd0);
        chk("midrst_cur_operand", 32'(operand), 32'd16);

        // Randomized advances and jumps against the expected address stream.
        exp_addr = 5'd16;
        for (int it = 0; it < 120; it++) begin
            lat = $urandom_range(1, 4);
            r   = $urandom_range(0, 9);
            if (r < 8) begin
                wait_unstall("rnd_unstall");
                w = word_of(exp_addr);
                chk("rnd_opcode",  32'(opcode),  32'(w[7:6]));
                chk("rnd_operand", 32'(operand), 32'(w[5:0]));
                next = 1'b1;
                cyc($urandom_range(1, 3));
                next = 1'b0;
                cyc(1);
                exp_addr = exp_addr + 5'd1;
            end else begin
                tgt = 5'($urandom_range(0, 31));
                load_pc = 1'b1; pc_in = tgt;
                if (r == 9) next = 1'b1;
                cyc(1);
                load_pc = 1'b0; next = 1'b0;
                cyc(1);
                exp_addr = tgt;
            end
            cyc($urandom_range(0, 2));
        end
        wait_unstall("rnd_final_unstall");
        w = word_of(exp_addr);
        chk("rnd_final_operand", 32'(operand), 32'(w[5:0]));
        chk("addr_stable_during_req", 32'(stable_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
